// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO for the Execute stage.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier; divides stay iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hilo_rdE,
    input  logic             hilo_selE,
    input  logic             hilo_wrE,
    input  logic [WIDTH-1:0] hilo_wdataE,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall_md
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     hi, lo, ma, mb;
    logic [2*WIDTH-1:0]   acc, step, prod;
    logic [CW-1:0]        count;
    logic                 is_div, neg_q, neg_r, div0;
    logic                 sa, sb, fast_start, ge;
    logic [WIDTH:0]       madd, rsh;
    logic [WIDTH-1:0]     q, r, lo_fix, hi_fix;
    logic [2*WIDTH-1:0]   fast_prod;

    assign sa = ~opE[0] & srcaE[WIDTH-1];
    assign sb = ~opE[0] & srcbE[WIDTH-1];

`ifdef MULDIV_FAST_MULT_EN
    assign fast_start = startE & ~opE[1];
    assign fast_prod  = {{WIDTH{sa}}, srcaE} * {{WIDTH{sb}}, srcbE};
`else
    assign fast_start = 1'b0;
    assign fast_prod  = '0;
`endif

    assign busy     = (state != IDLE);
    assign stall_md = busy & (startE | hilo_rdE | hilo_wrE);
    assign hilo_out = hilo_selE ? hi : lo;

    // multiply: add into the upper half, then shift the whole accumulator right
    assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mb[0] ? ma : '0)};
    // divide: restoring step, remainder in the upper half, quotient in the lower
    assign rsh  = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
    assign ge   = (rsh >= {1'b0, mb});

    always_comb begin
        step = '0;
        if (is_div)
            step = {(ge ? rsh[WIDTH-1:0] - mb : rsh[WIDTH-1:0]),
                    acc[WIDTH-2:0], ge};
        else
            step = {madd, acc[WIDTH-1:1]};
    end

    assign prod   = neg_q ? -acc : acc;
    assign q      = acc[WIDTH-1:0];
    assign r      = acc[2*WIDTH-1:WIDTH];
    // a zero divisor leaves the dividend magnitude in the remainder
    assign lo_fix = div0 ? '1 : (neg_q ? -q : q);
    assign hi_fix = neg_r ? -r : r;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (startE && !fast_start) state_n = ITER;
            ITER:    if (count == CW'(WIDTH - 1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            ma     <= '0;
            mb     <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fast_start) begin
                        {hi, lo} <= fast_prod;
                    end else if (startE) begin
                        ma     <= sa ? -srcaE : srcaE;
                        mb     <= sb ? -srcbE : srcbE;
                        is_div <= opE[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        div0   <= (srcbE == '0);
                        acc    <= '0;
                        count  <= '0;
                    end else if (hilo_wrE) begin
                        if (hilo_selE)
                            hi <= hilo_wdataE;
                        else
                            lo <= hilo_wdataE;
                    end
                end
                ITER: begin
                    acc   <= step;
                    count <= count + 1'b1;
                    if (is_div)
                        ma <= ma << 1;
                    else
                        mb <= mb >> 1;
                end
                FIX: begin
                    if (is_div)
                        {hi, lo} <= {hi_fix, lo_fix};
                    else
                        {hi, lo} <= prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: results queued at issue, checked at completion.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'd0;
    logic [31:0] srcaE = '0, srcbE = '0;
    logic        hilo_rdE = 1'b0, hilo_selE = 1'b0, hilo_wrE = 1'b0;
    logic [31:0] hilo_wdataE = '0;
    logic [31:0] hilo_out;
    logic        busy, stall_md;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sbq[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .hilo_rdE(hilo_rdE),
        .hilo_selE(hilo_selE), .hilo_wrE(hilo_wrE),
        .hilo_wdataE(hilo_wdataE), .hilo_out(hilo_out),
        .busy(busy), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] res;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (op)
            2'd0: res = sa * sb;
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0)
                    res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 0)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic read_hilo(output logic [63:0] v);
        hilo_selE = 1'b1;
        #1 v[63:32] = hilo_out;
        hilo_selE = 1'b0;
        #1 v[31:0] = hilo_out;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        sbq.push_back(model(op, a, b));
        @(negedge clk);
        startE = 1'b0;
    endtask

    task automatic finish_op(input logic [1:0] op, input int already);
        int n;
        int want;
        logic [63:0] v, e;
        n = 0;
        want = (FAST && !op[1]) ? 0 : 33 - already;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(want));
        read_hilo(v);
        e = (sbq.size() > 0) ? sbq.pop_front() : ~v;
        chk("hilo", v, e);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        issue(op, a, b);
        finish_op(op, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] v, e;
        int n;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall_md), 64'(0));
        read_hilo(v);
        chk("rst_hilo", v, 64'd0);
        reset = 1'b0;

        run(2'd0, 32'd7, 32'hFFFF_FFFD);
        run(2'd2, 32'hFFFF_FFF9, 32'd2);
        run(2'd3, 32'd100, 32'd7);
        run(2'd2, 32'd5, 32'd0);
        run(2'd2, 32'hFFFF_FFFB, 32'd0);
        run(2'd3, 32'h1234_5678, 32'd0);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd0, 32'h8000_0000, 32'h8000_0000);
        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd1, 32'hFFFF_FFFF, 32'd2);
        run(2'd2, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2) ? $urandom_range(1, 300) : $urandom;
            run(2'($urandom_range(0, 3)), a, b);
        end

        @(negedge clk);
        hilo_wrE = 1'b1; hilo_selE = 1'b1; hilo_wdataE = 32'hCAFE_0001;
        @(negedge clk);
        hilo_selE = 1'b0; hilo_wdataE = 32'h0BAD_0002;
        @(negedge clk);
        hilo_wrE = 1'b0;
        read_hilo(v);
        chk("mt_hilo", v, 64'hCAFE_0001_0BAD_0002);

        issue(2'd3, 32'd100, 32'd7);
        hilo_rdE = 1'b1;
        hilo_selE = 1'b0;
        #1;
        n = 0;
        while (stall_md && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 64'(n), 64'(33));
        e = (sbq.size() > 0) ? sbq.pop_front() : 64'hX;
        chk("mflo", {32'd0, hilo_out}, {32'd0, e[31:0]});
        hilo_rdE = 1'b0;

        issue(2'd2, 32'hFFFF_FF00, 32'd9);
        hilo_wrE = 1'b1; hilo_selE = 1'b1; hilo_wdataE = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        hilo_wrE = 1'b0;
        finish_op(2'd2, 3);

        issue(2'd3, 32'hFFFF_0000, 32'd3);
        void'(sbq.pop_back());
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        read_hilo(v);
        chk("midrst_hilo", v, 64'd0);
        run(2'd1, 32'd3, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU issued from the Execute stage. It also serves MFHI/MFLO/MTHI/MTLO, and raises a stall request to the hazard unit while a result is pending. It sits beside the ALU in Execute; its HI/LO read port feeds the Execute result mux.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; the only supported value is 32.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- startE  in  1  a mul/div instruction is valid in Execute this cycle.
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  32  rs operand (multiplicand / dividend).
- srcbE  in  32  rt operand (multiplier / divisor).
- hilo_rdE  in  1  MFHI or MFLO is in Execute.
- hilo_selE  in  1  0 selects LO, 1 selects HI, for both read and write.
- hilo_wrE  in  1  MTHI or MTLO is in Execute.
- hilo_wdataE  in  32  write data for MTHI/MTLO.
- hilo_out  out  32  combinational read of the selected HI or LO.
- busy  out  1  operation in flight.
- stall_md  out  1  stall request to the hazard unit.

## Operation
- Reset values: state=IDLE, hi=0, lo=0, busy=0, stall_md=0, count=0.
- State machine: IDLE -> ITER -> FIX -> IDLE.
- IDLE, startE=1:
  - Latch |srca| and |srcb|; magnitudes are taken only for signed ops.
  - Latch the result sign: for MULT the XOR of the sign bits; for DIV the quotient sign is the XOR and the remainder sign follows the dividend.
  - Clear the 64-bit accumulator, set count=0, go to ITER.
- ITER:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring-division step per cycle, producing one quotient bit per cycle.
  - count increments each cycle; after the step with count=31, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write HI/LO: mult gives {hi,lo} = 64-bit product; div gives lo = quotient and hi = remainder.
  - Return to IDLE.
- Division rules:
  - Signed quotient truncates toward zero.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero, fixed result: lo=0xFFFFFFFF and hi=dividend. The normal 32 cycles are still taken.
- MTHI/MTLO (hilo_wrE) are accepted only in IDLE; they write the selected register on the edge.
- stall_md = busy & (startE | hilo_rdE | hilo_wrE).
  - While stalled, the pipeline holds Execute, so the same request is re-presented.
  - The block ignores startE and hilo_wrE while busy.
- hilo_out always reflects the current registers. It is stale while busy; stall_md prevents its use.
- startE and hilo_wrE together in IDLE: the operation starts and the MT write is dropped. The decoder never issues both.

## Timing
- startE sampled at edge E0.
- busy=1 from after E0 through edge E0+33: 33 cycles, 32 ITER plus 1 FIX.
- HI/LO are updated at edge E0+33; busy=0 and the result is readable on hilo_out in the following cycle.
- Back-to-back operations: a new startE is accepted in the first cycle with busy=0, giving a 34-cycle issue interval.
- MTHI/MTLO latency is 1: the written value is visible on hilo_out the cycle after the edge.
- Reset mid-operation: at the next edge, abandon the operation, return to IDLE, clear HI/LO, and drop busy.

## Configuration
- MULDIV_FAST_MULT_EN defined:
  - MULT/MULTU use a single-cycle 32x32 multiplier.
  - HI/LO are written at edge E0; busy never rises for a multiply.
  - Division is unchanged.
- MULDIV_FAST_MULT_EN undefined: all four ops use the 33-cycle sequence above.

## Test plan
- MULT 7 x -3: after 33 busy cycles, hi=0xFFFFFFFF and lo=0xFFFFFFEB; busy falls at edge E0+33.
- DIV -7 / 2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 gives lo=0x0000000E, hi=0x00000002.
- DIV 5 / 0 gives lo=0xFFFFFFFF, hi=0x00000005 after the full 33 cycles.
- MFLO asserted at E0+1 while busy:
  - stall_md=1 for cycles E0+1 through E0+33.
  - hilo_out is sampled in the first unstalled cycle and equals the new LO.
- reset asserted at E0+10 mid-DIVU: the next cycle shows busy=0 and hi=lo=0; a new MULTU 3x4 then yields lo=12, hi=0.
- With MULDIV_FAST_MULT_EN: MULTU 0xFFFFFFFF x 2 gives hi=1, lo=0xFFFFFFFE one cycle after E0, with busy=0 throughout.
